cordic_sequencer: RTL and testbench

Iteration controller for the single-step CORDIC compute unit. It drives the controller side of the core interface and sequences one operation through N micro-rotations. Each operation is a vector (x, y, z) with a mode (rotation or vectoring) and a system (circular or hyperbolic). It fetches per-step angles from an external arctan/artanh LUT, tracks overflow, and returns the result over a valid/ready handshake. It sits between the register/bus front-end and the compute unit.

---
 rtl/cordic_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cordic_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sequencer.sv
// Iteration controller for the single-step CORDIC core: accepts (x,y,z), runs the micro-rotation
// schedule, returns the result. Optional CORDIC_OVERFLOW_ABORT_EN ends an operation on first overflow.
module cordic_sequencer #(
  parameter  int unsigned p_WIDTH      = 32,
  parameter  int unsigned p_ITERATIONS = 24,
  localparam int unsigned p_LOG2_WIDTH = $clog2(p_WIDTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic                           inMode,
  input  logic                           inSystem,
  input  logic signed [p_WIDTH-1:0]      xIn,
  input  logic signed [p_WIDTH-1:0]      yIn,
  input  logic signed [p_WIDTH-1:0]      zIn,
  output logic signed [p_WIDTH-1:0]      xPrev,
  output logic signed [p_WIDTH-1:0]      yPrev,
  output logic signed [p_WIDTH-1:0]      zPrev,
  output logic                           rotationDir,
  output logic                           rotationSystem,
  output logic        [p_WIDTH-1:0]      rotationAngle,
  output logic        [p_LOG2_WIDTH-1:0] shiftAmount,
  input  logic signed [p_WIDTH-1:0]      xResult,
  input  logic signed [p_WIDTH-1:0]      yResult,
  input  logic signed [p_WIDTH-1:0]      zResult,
  input  logic                           xOverflow,
  input  logic                           yOverflow,
  input  logic                           zOverflow,
  output logic        [p_LOG2_WIDTH-1:0] lutIndex,
  output logic                           lutSystem,
  input  logic        [p_WIDTH-1:0]      lutAngle,
  output logic                           outValid,
  input  logic                           outReady,
  output logic signed [p_WIDTH-1:0]      xOut,
  output logic signed [p_WIDTH-1:0]      yOut,
  output logic signed [p_WIDTH-1:0]      zOut,
  output logic        [2:0]              overflowOut
`ifdef CORDIC_OVERFLOW_ABORT_EN
  ,
  output logic                           abortedOut
`endif
);

  localparam logic [p_LOG2_WIDTH-1:0] MAX_SHIFT = p_LOG2_WIDTH'(p_WIDTH - 1);
  localparam logic [p_LOG2_WIDTH-1:0] LAST_STEP = p_LOG2_WIDTH'(p_ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                    state, state_d;
  logic                      mode_q, system_q, repeat_pending, repeat_d, out_valid_q;
  logic [p_LOG2_WIDTH-1:0]   step_count, shift_index, shift_d;
  logic [2:0]                sticky, step_ovf;
  logic                      accept, stop_iter, is_repeat;
`ifdef CORDIC_OVERFLOW_ABORT_EN
  logic                      aborted_q;
`endif

  // Next state and handshake decode
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    step_ovf  = {xOverflow, yOverflow, zOverflow};
`ifdef CORDIC_OVERFLOW_ABORT_EN
    stop_iter = (step_count == LAST_STEP) || (|step_ovf);
`else
    stop_iter = (step_count == LAST_STEP);
`endif
    case (state)
      IDLE: if (inValid) begin
        accept  = 1'b1;
        state_d = ITER;
      end
      ITER: if (stop_iter) state_d = DONE;
      DONE: if (outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hyperbolic schedule repeats indices 4, 13 and 40 once; index saturates at p_WIDTH-1
  always_comb begin
    shift_d   = shift_index;
    repeat_d  = repeat_pending;
    is_repeat = (32'(shift_index) == 32'd4) || (32'(shift_index) == 32'd13) ||
                (32'(shift_index) == 32'd40);
    if (!system_q && is_repeat && !repeat_pending) begin
      repeat_d = 1'b1;
    end else begin
      repeat_d = 1'b0;
      if (shift_index != MAX_SHIFT) shift_d = shift_index + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xPrev          <= '0;
      yPrev          <= '0;
      zPrev          <= '0;
      mode_q         <= 1'b0;
      system_q       <= 1'b0;
      sticky         <= '0;
      step_count     <= '0;
      shift_index    <= '0;
      repeat_pending <= 1'b0;
      out_valid_q    <= 1'b0;
`ifdef CORDIC_OVERFLOW_ABORT_EN
      aborted_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          xPrev          <= xIn;
          yPrev          <= yIn;
          zPrev          <= zIn;
          mode_q         <= inMode;
          system_q       <= inSystem;
          sticky         <= '0;
          step_count     <= '0;
          shift_index    <= inSystem ? p_LOG2_WIDTH'(0) : p_LOG2_WIDTH'(1);
          repeat_pending <= 1'b0;
`ifdef CORDIC_OVERFLOW_ABORT_EN
          aborted_q      <= 1'b0;
`endif
        end
        ITER: begin
          xPrev          <= xResult;
          yPrev          <= yResult;
          zPrev          <= zResult;
          sticky         <= sticky | step_ovf;
          step_count     <= step_count + 1'b1;
          shift_index    <= shift_d;
          repeat_pending <= repeat_d;
          if (stop_iter) begin
            out_valid_q <= 1'b1;
`ifdef CORDIC_OVERFLOW_ABORT_EN
            aborted_q   <= |step_ovf;
`endif
          end
        end
        DONE: if (outReady) begin
          out_valid_q <= 1'b0;
`ifdef CORDIC_OVERFLOW_ABORT_EN
          aborted_q   <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Rotation drives z toward 0, vectoring drives y toward 0
  assign rotationDir    = mode_q ? ~yPrev[p_WIDTH-1] : zPrev[p_WIDTH-1];
  assign inReady        = (state == IDLE);
  assign rotationSystem = system_q;
  assign lutSystem      = system_q;
  assign shiftAmount    = shift_index;
  assign lutIndex       = shift_index;
  assign rotationAngle  = lutAngle;
  assign outValid       = out_valid_q;
  assign xOut           = xPrev;
  assign yOut           = yPrev;
  assign zOut           = zPrev;
  assign overflowOut    = sticky;
`ifdef CORDIC_OVERFLOW_ABORT_EN
  assign abortedOut     = aborted_q;
`endif

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: behavioural CORDIC core and LUT, per-cycle reference model.
module tb_cordic_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 15;
  localparam int unsigned LW = $clog2(W);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, inValid, inReady, inMode, inSystem;
  logic signed [W-1:0] xIn, yIn, zIn, xPrev, yPrev, zPrev;
  logic signed [W-1:0] xResult, yResult, zResult, xOut, yOut, zOut;
  logic rotationDir, rotationSystem, lutSystem, outValid, outReady;
  logic [W-1:0] rotationAngle, lutAngle;
  logic [LW-1:0] shiftAmount, lutIndex;
  logic xOverflow, yOverflow, zOverflow;
  logic [2:0] overflowOut;
`ifdef CORDIC_OVERFLOW_ABORT_EN
  logic abortedOut;
`endif

  cordic_sequencer #(.p_WIDTH(W), .p_ITERATIONS(N)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .inMode(inMode),
    .inSystem(inSystem), .xIn(xIn), .yIn(yIn), .zIn(zIn), .xPrev(xPrev), .yPrev(yPrev),
    .zPrev(zPrev), .rotationDir(rotationDir), .rotationSystem(rotationSystem),
    .rotationAngle(rotationAngle), .shiftAmount(shiftAmount), .xResult(xResult),
    .yResult(yResult), .zResult(zResult), .xOverflow(xOverflow), .yOverflow(yOverflow),
    .zOverflow(zOverflow), .lutIndex(lutIndex), .lutSystem(lutSystem), .lutAngle(lutAngle),
    .outValid(outValid), .outReady(outReady), .xOut(xOut), .yOut(yOut), .zOut(zOut),
    .overflowOut(overflowOut)
`ifdef CORDIC_OVERFLOW_ABORT_EN
    , .abortedOut(abortedOut)
`endif
  );

  // atan / atanh of 2^-i scaled by 2^13
  int circ_lut [16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 0};
  int hyp_lut  [16] = '{0, 4500, 2092, 1029, 513, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 0};
  int hyp_expect [N] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};

  function automatic logic signed [W-1:0] lut(input logic sys, input int idx);
    return sys ? W'(circ_lut[idx]) : W'(hyp_lut[idx]);
  endfunction

  function automatic logic [3*W-1:0] rot(input logic signed [W-1:0] x, y, z, input logic dir,
                                         input logic sys, input int sh,
                                         input logic signed [W-1:0] ang);
    logic signed [W-1:0] xs, ys, nx, ny, nz;
    xs = x >>> sh;
    ys = y >>> sh;
    if (sys) nx = dir ? x + ys : x - ys;
    else     nx = dir ? x - ys : x + ys;
    ny = dir ? y - xs : y + xs;
    nz = dir ? z + ang : z - ang;
    return {nx, ny, nz};
  endfunction

  assign lutAngle = lut(lutSystem, int'(lutIndex));
  always_comb {xResult, yResult, zResult} =
    rot(xPrev, yPrev, zPrev, rotationDir, rotationSystem, int'(shiftAmount), rotationAngle);

  int n_chk  = 0;
  int n_pass = 0;
  int sched   [N];
  int obs_shift [N];
  logic dir0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
  endtask

  // Shift schedule straight from the rules: circular 0,1,2..; hyperbolic 1,2.. with 4/13/40 twice
  task automatic build_sched(input logic sys);
    int idx, k;
    if (sys) begin
      for (int i = 0; i < N; i++) sched[i] = (i < W - 1) ? i : W - 1;
    end else begin
      idx = 1;
      k   = 0;
      while (k < N) begin
        sched[k] = idx;
        k++;
        if ((idx == 4 || idx == 13 || idx == 40) && k < N) begin
          sched[k] = idx;
          k++;
        end
        if (idx < W - 1) idx++;
      end
    end
  endtask

  task automatic run_op(input logic mode, input logic sys, input logic signed [W-1:0] x0, y0, z0,
                        input int inj_step, input logic [2:0] inj_mask, input int bp,
                        input int rst_step);
    logic signed [W-1:0] mx, my, mz;
    logic [2:0] msticky;
    logic mdir;
    int n_exp;
    build_sched(sys);
    n_exp = N;
`ifdef CORDIC_OVERFLOW_ABORT_EN
    if (inj_step >= 0 && inj_step < N && inj_mask != 3'b000) n_exp = inj_step + 1;
`endif
    @(negedge clk);
    inMode = mode; inSystem = sys; xIn = x0; yIn = y0; zIn = z0; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    mx = x0; my = y0; mz = z0; msticky = 3'b000;
    for (int k = 0; k < n_exp; k++) begin
      mdir = mode ? (my >= 0) : (mz < 0);
      obs_shift[k] = int'(shiftAmount);
      if (k == 0) dir0 = rotationDir;
      chk("busy_out_valid", 32'(outValid), 0);
      chk("busy_in_ready", 32'(inReady), 0);
      chk("shift_amount", 32'(shiftAmount), sched[k]);
      chk("lut_index", 32'(lutIndex), sched[k]);
      chk("lut_system", 32'(lutSystem), 32'(sys));
      chk("rotation_dir", 32'(rotationDir), 32'(mdir));
      chk("x_prev", 32'(xPrev), 32'(mx));
      chk("y_prev", 32'(yPrev), 32'(my));
      chk("z_prev", 32'(zPrev), 32'(mz));
      if (k == rst_step) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(outValid), 0);
        chk("rst_in_ready", 32'(inReady), 1);
        chk("rst_x_prev", 32'(xPrev), 0);
        chk("rst_y_prev", 32'(yPrev), 0);
        chk("rst_z_prev", 32'(zPrev), 0);
        chk("rst_overflow", 32'(overflowOut), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < N + 3; j++) begin
          @(negedge clk);
          chk("post_rst_no_result", 32'(outValid), 0);
        end
        chk("post_rst_in_ready", 32'(inReady), 1);
        return;
      end
      {xOverflow, yOverflow, zOverflow} = (k == inj_step) ? inj_mask : 3'b000;
      if (k == inj_step) msticky = msticky | inj_mask;
      {mx, my, mz} = rot(mx, my, mz, mdir, sys, sched[k], lut(sys, sched[k]));
      @(negedge clk);
    end
    {xOverflow, yOverflow, zOverflow} = 3'b000;
    chk("done_out_valid", 32'(outValid), 1);
    chk("done_in_ready", 32'(inReady), 0);
    chk("x_out", 32'(xOut), 32'(mx));
    chk("y_out", 32'(yOut), 32'(my));
    chk("z_out", 32'(zOut), 32'(mz));
    chk("overflow_out", 32'(overflowOut), 32'(msticky));
`ifdef CORDIC_OVERFLOW_ABORT_EN
    chk("aborted_out", 32'(abortedOut), 32'(n_exp < N));
`endif
    for (int j = 0; j < bp; j++) begin
      inValid = 1'b1; xIn = 16'sh1234;
      @(negedge clk);
      chk("bp_out_valid", 32'(outValid), 1);
      chk("bp_in_ready", 32'(inReady), 0);
      chk("bp_x_out", 32'(xOut), 32'(mx));
      chk("bp_z_out", 32'(zOut), 32'(mz));
    end
    inValid = 1'b1; outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0; outReady = 1'b0;
    chk("release_out_valid", 32'(outValid), 0);
    chk("release_in_ready", 32'(inReady), 1);
    chk("idle_hold_x", 32'(xPrev), 32'(mx));
    @(negedge clk);
    chk("idle_hold_y", 32'(yPrev), 32'(my));
  endtask

  initial begin
    int ya;
    reset = 1'b1; inValid = 1'b0; inMode = 1'b0; inSystem = 1'b0; outReady = 1'b0;
    xIn = '0; yIn = '0; zIn = '0;
    {xOverflow, yOverflow, zOverflow} = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(outValid), 0);
    chk("reset_in_ready", 32'(inReady), 1);
    chk("reset_x_prev", 32'(xPrev), 0);
    chk("reset_shift", 32'(shiftAmount), 0);
    chk("reset_overflow", 32'(overflowOut), 0);
    reset = 1'b0;

    // Circular rotation, z<0, with 10 cycles of backpressure
    run_op(1'b0, 1'b1, 16'sd4000, 16'sd0, -16'sd5, -1, 3'b000, 10, -1);
    chk("circ_first_dir_literal", 32'(dir0), 1);
    for (int k = 0; k < N; k++) chk("circ_shift_literal", obs_shift[k], k);

    // Hyperbolic rotation
    run_op(1'b0, 1'b0, 16'sd4000, 16'sd0, 16'sd1000, -1, 3'b000, 0, -1);
    for (int k = 0; k < N; k++) chk("hyp_shift_literal", obs_shift[k], hyp_expect[k]);

    // Circular vectoring, y>0
    run_op(1'b1, 1'b1, 16'sd200, 16'sd100, 16'sd0, -1, 3'b000, 2, -1);
    chk("vec_first_dir_literal", 32'(dir0), 1);
    ya = int'(yOut);
    if (ya < 0) ya = -ya;
    chk("vec_y_near_zero", 32'(ya <= 2), 1);

    // Reset during step 7
    run_op(1'b0, 1'b1, 16'sd3000, 16'sd1000, -16'sd3000, -1, 3'b000, 0, 7);

    // y overflow at step 3
    run_op(1'b0, 1'b1, 16'sd3000, 16'sd0, 16'sd2000, 3, 3'b010, 1, -1);
    chk("ovf_sticky_literal", 32'(overflowOut), 32'(3'b010));

    // Back-to-back operation after the overflow one clears sticky
    run_op(1'b1, 1'b0, 16'sd3000, 16'sd500, 16'sd0, -1, 3'b000, 0, -1);
    chk("ovf_cleared_literal", 32'(overflowOut), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
